// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the K=9 rate-1/2 code used by the encoder and
// the Viterbi decoder (generators, state/symbol types, encoder FSM encoding).
package viterbi_pkg;

    localparam int         K        = 9;
    localparam int         M        = K - 1;
    localparam int         NUM_ST   = 1 << M;
    localparam logic [8:0] G0       = 9'o561;
    localparam logic [8:0] G1       = 9'o753;
    localparam int         TAIL_LEN = M;

    typedef logic [M-1:0] st_t;
    typedef logic [1:0]   sym_t;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_DATA = 2'd1,
        ENC_TAIL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// One trellis step: maps (input bit, current state) to the code symbol and the
// successor state. Purely combinational so the decoder can reuse it per branch.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [8:0] G0 = viterbi_pkg::G0,
    parameter logic [8:0] G1 = viterbi_pkg::G1
) (
    input  logic       i_u,
    input  logic [7:0] i_st,
    output logic [1:0] o_sym,
    output logic [7:0] o_st_next
);

    logic [K-1:0] w_win;

    // i_st[7] is the most recent past input, so it sits directly below u.
    assign w_win     = {i_u, i_st};
    assign o_sym     = {^(w_win & G1), ^(w_win & G0)};
    assign o_st_next = {i_u, i_st[M-1:1]};

endmodule

// File: rtl/conv_encoder_tx.sv
// Frame-based K=9 rate-1/2 convolutional encoder: FRAME_LEN information bits
// followed by 8 zero tail bits, one registered symbol slot with valid/ready.
module conv_encoder_tx
    import viterbi_pkg::*;
#(
    parameter int         FRAME_LEN = 256,
    parameter logic [8:0] G0        = viterbi_pkg::G0,
    parameter logic [8:0] G1        = viterbi_pkg::G1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_e,
    input  logic       i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [1:0] o_sym,
    output logic       o_sym_valid,
    input  logic       i_sym_ready,
    output logic       o_sof,
    output logic       o_eof,
    output logic [7:0] o_st,
    output logic       o_busy
);

    localparam int            CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
    localparam logic [2:0]    TAIL_LAST = 3'(TAIL_LEN - 1);

    enc_state_e    r_state;
    enc_state_e    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_tail_cnt;
    logic [2:0]    w_tail_cnt_next;
    logic [7:0]    r_st;
    logic [1:0]    r_sym;
    logic          r_sym_valid;
    logic          r_sof;
    logic          r_eof;

    logic [1:0]    w_sym_next;
    logic          w_sym_valid_next;
    logic          w_sof_next;
    logic          w_eof_next;

    logic          w_slot_free;
    logic          w_in_phase;
    logic          w_accept;
    logic          w_tail_step;
    logic          w_load;
    logic          w_u;
    logic [1:0]    w_core_sym;
    logic [7:0]    w_core_st_next;

    assign w_slot_free = !r_sym_valid || i_sym_ready;
    assign w_in_phase  = (r_state == ENC_IDLE) || (r_state == ENC_DATA);
    assign o_ready     = en_e && w_slot_free && w_in_phase;
    assign w_accept    = i_valid && o_ready;
    assign w_tail_step = en_e && w_slot_free && (r_state == ENC_TAIL);
    assign w_load      = w_accept || w_tail_step;
    assign w_u         = (r_state == ENC_TAIL) ? 1'b0 : i_data;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .i_u       (w_u),
        .i_st      (r_st),
        .o_sym     (w_core_sym),
        .o_st_next (w_core_st_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ENC_IDLE;
        end else if (en_e) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_tail_cnt_next = r_tail_cnt;
        unique case (r_state)
            ENC_IDLE: begin
                if (w_accept) begin
                    if (FRAME_LEN == 1) begin
                        w_state_next = ENC_TAIL;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = ENC_DATA;
                        w_cnt_next   = CW'(1);
                    end
                end
            end
            ENC_DATA: begin
                if (w_accept) begin
                    if (r_cnt == LAST_CNT) begin
                        w_state_next = ENC_TAIL;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + CW'(1);
                    end
                end
            end
            ENC_TAIL: begin
                if (w_tail_step) begin
                    w_tail_cnt_next = r_tail_cnt + 3'd1;
                    if (r_tail_cnt == TAIL_LAST) begin
                        w_state_next = ENC_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ENC_IDLE;
            end
        endcase
    end

    // A slot that is consumed without a new load simply empties.
    always_comb begin
        w_sym_next       = r_sym;
        w_sym_valid_next = r_sym_valid;
        w_sof_next       = r_sof;
        w_eof_next       = r_eof;
        if (w_load) begin
            w_sym_next       = w_core_sym;
            w_sym_valid_next = 1'b1;
            w_sof_next       = (r_state == ENC_IDLE);
            w_eof_next       = w_tail_step && (r_tail_cnt == TAIL_LAST);
        end else if (i_sym_ready) begin
            w_sym_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_tail_cnt  <= '0;
            r_st        <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else if (en_e) begin
            r_cnt       <= w_cnt_next;
            r_tail_cnt  <= w_tail_cnt_next;
            r_st        <= w_load ? w_core_st_next : r_st;
            r_sym       <= w_sym_next;
            r_sym_valid <= w_sym_valid_next;
            r_sof       <= w_sof_next;
            r_eof       <= w_eof_next;
        end
    end

    // The slot is frozen while disabled, so valid is hidden to keep a
    // downstream consumer from taking the same symbol twice.
    assign o_sym_valid = r_sym_valid && en_e;
    assign o_sym       = r_sym;
    assign o_sof       = r_sof;
    assign o_eof       = r_eof;
    assign o_st        = r_st;
    assign o_busy      = (r_state != ENC_IDLE);

endmodule
